// File: rtl/amber128_pkg.sv
// amber128 shared definitions.
// Holds the datapath width, the data-memory arbiter state encoding and the
// latched memory command type used by amber128_dmem_arb.
package amber128_pkg;

    localparam int unsigned C_XLEN = 128;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_RESP
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [63:0]       addr;
        logic [C_XLEN-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/amber128_rr_pick.sv
// Combinational round-robin picker.
// Searches req_i upward starting just above last_i, wrapping around, and
// returns the first requester found.
//   req_i   : request vector
//   last_i  : index of the previously granted requester
//   gnt_o   : one-hot winner (0 if no request)
//   idx_o   : binary index of the winner
//   valid_o : some requester was selected
module amber128_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        // k = NUM_REQ wraps back to last_i itself, so a lone requester still wins.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_i) + k) % NUM_REQ);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/amber128_dmem_arb.sv
// Round-robin arbiter in front of the single-port amber128 data memory.
// Accesses are serialised: IDLE (arbitrate) -> ISSUE (one-cycle mem_req_o)
// -> WAIT (memory answer or retry) -> RESP (one-cycle ready_o). An access
// the memory never accepts is completed as a trap after MAX_RETRY attempts.
//   req_i/we_i/addr_i/wdata_i : per-requester command, held until ready_o
//   ready_o/trap_o/rdata_o    : completion pulse, fault flag, read data
//   grant_o                   : one-hot current owner (debug)
//   mem_*                     : single request channel to amber128_dmem
module amber128_dmem_arb
    import amber128_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned MAX_RETRY = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ-1:0]              we_i,
    input  logic [NUM_REQ-1:0][63:0]        addr_i,
    input  logic [NUM_REQ-1:0][C_XLEN-1:0]  wdata_i,
    output logic [NUM_REQ-1:0]              ready_o,
    output logic [C_XLEN-1:0]               rdata_o,
    output logic [NUM_REQ-1:0]              trap_o,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            mem_req_o,
    output logic                            mem_we_o,
    output logic [63:0]                     mem_addr_o,
    output logic [C_XLEN-1:0]               mem_wdata_o,
    input  logic [C_XLEN-1:0]               mem_rdata_i,
    input  logic                            mem_ready_i,
    input  logic                            mem_trap_i
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);

    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] last_q;
    logic [CNT_W-1:0] cnt_q;
    dmem_req_t        cmd_q;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    amber128_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // The memory always sees the latched command; mem_req_o qualifies it.
    assign mem_we_o    = cmd_q.we;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;

    // mem_req_o, ready_o and trap_o are registered: each is set on the edge
    // that enters ISSUE / RESP, so it is high for exactly that one state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            cnt_q     <= '0;
            cmd_q     <= '0;
            ready_o   <= '0;
            trap_o    <= '0;
            rdata_o   <= '0;
            grant_o   <= '0;
            mem_req_o <= 1'b0;
        end else begin
            ready_o   <= '0;
            trap_o    <= '0;
            mem_req_o <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        cmd_q     <= '{we:    we_i[pick_idx],
                                       addr:  addr_i[pick_idx],
                                       wdata: wdata_i[pick_idx]};
                        owner_q   <= pick_idx;
                        last_q    <= pick_idx;
                        grant_o   <= pick_gnt;
                        cnt_q     <= '0;
                        mem_req_o <= 1'b1;
                        state_q   <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (mem_ready_i) begin
                        rdata_o          <= mem_rdata_i;
                        ready_o[owner_q] <= 1'b1;
                        trap_o[owner_q]  <= mem_trap_i;
                        state_q          <= ARB_RESP;
                    end else if (cnt_q == CNT_W'(MAX_RETRY)) begin
                        // Attempts exhausted: complete as a fault.
                        rdata_o          <= '0;
                        ready_o[owner_q] <= 1'b1;
                        trap_o[owner_q]  <= 1'b1;
                        state_q          <= ARB_RESP;
                    end else begin
                        mem_req_o <= 1'b1;
                        state_q   <= ARB_ISSUE;
                    end
                end
                ARB_RESP: begin
                    // No arbitration here so the served requester can drop req_i.
                    grant_o <= '0;
                    state_q <= ARB_IDLE;
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amber128_dmem_arb.sv
module tb_amber128_dmem_arb;
    import amber128_pkg::*;

    localparam int N    = 2;
    localparam int MAXR = 4;

    logic                       clk;
    logic                       rst_n;
    logic [N-1:0]               req;
    logic [N-1:0]               we;
    logic [N-1:0][63:0]         addr;
    logic [N-1:0][C_XLEN-1:0]   wdata;
    logic [N-1:0]               ready;
    logic [C_XLEN-1:0]          rdata;
    logic [N-1:0]               trap;
    logic [N-1:0]               grant;
    logic                       mem_req;
    logic                       mem_we;
    logic [63:0]                mem_addr;
    logic [C_XLEN-1:0]          mem_wdata;
    logic [C_XLEN-1:0]          mem_rdata;
    logic                       mem_ready;
    logic                       mem_trap;

    amber128_dmem_arb #(
        .NUM_REQ   (N),
        .MAX_RETRY (MAXR)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .ready_o     (ready),
        .rdata_o     (rdata),
        .trap_o      (trap),
        .grant_o     (grant),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready),
        .mem_trap_i  (mem_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [C_XLEN-1:0] act,
                         input logic [C_XLEN-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- bench-side data memory ----------------
    logic [C_XLEN-1:0] mem_arr [64];
    int stall_pct = 0;
    bit dead = 1'b0;

    initial begin
        logic             seen, w, st;
        logic [63:0]      a;
        logic [C_XLEN-1:0] d;
        for (int i = 0; i < 64; i++) mem_arr[i] = '0;
        mem_ready = 1'b0;
        mem_trap  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            seen = mem_req && rst_n;
            a    = mem_addr;
            w    = mem_we;
            d    = mem_wdata;
            st   = dead || ($urandom_range(99) < stall_pct);
            @(posedge clk);
            #1;
            if (seen && !st) begin
                mem_ready = 1'b1;
                mem_trap  = (a[3:0] != 4'h0);
                if (mem_trap) mem_rdata = '0;
                else if (w) begin
                    mem_arr[a[9:4]] = d;
                    mem_rdata       = '0;
                end else mem_rdata = mem_arr[a[9:4]];
            end else begin
                mem_ready = 1'b0;
                mem_trap  = 1'b0;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ---------------- behavioural reference model + compare ----------------
    // Access timeline relative to the grant cycle g: attempts at g+1, g+3, ...
    // the cycle after each attempt decides success/retry/exhaustion, and the
    // response follows that deciding cycle.
    int                m_last = N - 1;
    bit                m_busy = 1'b0;
    bit                m_resp = 1'b0;
    int                m_own = 0;
    int                m_n = 0;
    int                m_att = 0;
    logic              m_we = 1'b0;
    logic [63:0]       m_addr = '0;
    logic [C_XLEN-1:0] m_wdata = '0;
    logic [C_XLEN-1:0] m_hold = '0;
    logic [C_XLEN-1:0] m_next = '0;
    logic              m_rtrap = 1'b0;

    always @(negedge clk) begin
        logic [N-1:0] e_ready, e_trap, e_grant;
        logic         e_mreq;
        bit           found;
        int           j;
        e_ready = '0;
        e_trap  = '0;
        e_grant = '0;
        e_mreq  = 1'b0;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
            m_last = N - 1;
            m_hold = '0;
        end else if (m_resp) begin
            e_ready[m_own] = 1'b1;
            e_trap[m_own]  = m_rtrap;
            e_grant[m_own] = 1'b1;
            m_hold         = m_next;
            m_resp         = 1'b0;
            m_busy         = 1'b0;
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (!found && req[j]) begin
                    found = 1'b1;
                    m_own = j;
                end
            end
            if (found) begin
                m_busy  = 1'b1;
                m_last  = m_own;
                m_n     = 0;
                m_att   = 0;
                m_we    = we[m_own];
                m_addr  = addr[m_own];
                m_wdata = wdata[m_own];
            end
        end else begin
            m_n++;
            e_grant[m_own] = 1'b1;
            if (m_n % 2 == 1) begin
                e_mreq = 1'b1;
                m_att++;
                check("m_mem_we", mem_we, m_we);
                check("m_mem_addr", mem_addr, m_addr);
                check("m_mem_wdata", mem_wdata, m_wdata);
            end else if (mem_ready) begin
                m_resp  = 1'b1;
                m_next  = mem_rdata;
                m_rtrap = mem_trap;
            end else if (m_att == MAXR) begin
                m_resp  = 1'b1;
                m_next  = '0;
                m_rtrap = 1'b1;
            end
        end
        check("m_ready", ready, e_ready);
        check("m_trap", trap, e_trap);
        check("m_grant", grant, e_grant);
        check("m_mem_req", mem_req, e_mreq);
        check("m_rdata", rdata, m_hold);
    end

    // ---------------- directed + random stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int i, input logic w, input logic [63:0] a,
                         input logic [C_XLEN-1:0] d);
        req[i]   = 1'b1;
        we[i]    = w;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    initial begin
        int               pulses, idx, prev_t, t;
        logic [N-1:0]     seen_rdy;
        logic [N-1:0]     exp_oh;
        int               stale;
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (3) @(posedge clk);
        check("rst_ready", ready, '0);
        check("rst_grant", grant, '0);
        check("rst_mem_req", mem_req, '0);
        #1 rst_n = 1'b1;

        // Single write then back-to-back read of the same word.
        @(posedge clk); #1;
        drive(0, 1'b1, 64'h40, 128'hDEAD);
        cyc(1); check("w_c0_mem_req", mem_req, 1'b0);
        cyc(1); check("w_c1_mem_req", mem_req, 1'b1);
        check("w_c1_addr", mem_addr, 64'h40);
        check("w_c1_grant", grant, 2'b01);
        cyc(1); check("w_c2_mem_req", mem_req, 1'b0);
        cyc(1); check("w_c3_ready", ready, 2'b01);
        check("w_c3_trap", trap, 2'b00);
        @(posedge clk); #1;
        we[0] = 1'b0;
        cyc(4); check("r_c7_ready", ready, 2'b01);
        check("r_c7_rdata", rdata, 128'hDEAD);
        @(posedge clk); #1;
        req = '0;

        // Retry exhaustion: memory never answers.
        dead = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h80, '0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_req) pulses++;
            if (ready[0]) break;
        end
        check("exh_pulses", pulses, 4);
        check("exh_ready", ready, 2'b01);
        check("exh_trap", trap, 2'b01);
        check("exh_rdata", rdata, '0);
        @(posedge clk); #1;
        req  = '0;
        dead = 1'b0;

        // Misaligned access traps, then the waiting requester 1 is served.
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h41, '0);
        @(posedge clk); #1;
        drive(1, 1'b0, 64'h40, '0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready != '0) break;
        end
        check("mis_ready", ready, 2'b01);
        check("mis_trap", trap, 2'b01);
        @(posedge clk); #1;
        req[0] = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (grant != '0) break;
        end
        check("mis_next_grant", grant, 2'b10);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready[1]) break;
        end
        check("mis_r1_rdata", rdata, 128'hDEAD);
        @(posedge clk); #1;
        req = '0;

        // Contention: both held, strict alternation, 4-cycle spacing.
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h40, '0);
        drive(1, 1'b1, 64'h90, 128'h1234);
        idx    = 0;
        prev_t = -1;
        t      = 0;
        for (int k = 0; k < 60 && idx < 8; k++) begin
            @(negedge clk);
            t++;
            if (ready != '0) begin
                exp_oh = (idx % 2 == 0) ? 2'b01 : 2'b10;
                check("cont_owner", ready, exp_oh);
                if (prev_t >= 0) check("cont_gap", 32'(t - prev_t), 32'd4);
                prev_t = t;
                idx++;
            end
        end
        check("cont_count", idx, 8);
        @(posedge clk); #1;
        req = '0;
        cyc(6);

        // Randomised traffic with stalling memory.
        stall_pct = 30;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            seen_rdy = ready;
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (req[i] && seen_rdy[i]) begin
                    if ($urandom_range(1) == 1) req[i] = 1'b0;
                    else drive(i, 1'($urandom_range(1)),
                               64'($urandom_range(15) * 16 + ($urandom_range(7) == 0 ? 1 : 0)),
                               {$urandom, $urandom, $urandom, $urandom});
                end else if (!req[i] && $urandom_range(2) == 0) begin
                    drive(i, 1'($urandom_range(1)),
                          64'($urandom_range(15) * 16 + ($urandom_range(7) == 0 ? 1 : 0)),
                          {$urandom, $urandom, $urandom, $urandom});
                end
            end
        end
        req       = '0;
        stall_pct = 0;
        cyc(20);

        // Reset while in WAIT.
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h40, '0);
        cyc(3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", ready, '0);
        check("arst_trap", trap, '0);
        check("arst_grant", grant, '0);
        check("arst_mem_req", mem_req, '0);
        check("arst_rdata", rdata, '0);
        check("arst_mem_addr", mem_addr, '0);
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(0, 1'b0, 64'h40, '0);
        drive(1, 1'b0, 64'h40, '0);
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ready != '0) stale++;
            if (grant != '0) break;
        end
        check("post_rst_stale", stale, 0);
        check("post_rst_grant", grant, 2'b01);
        @(posedge clk); #1;
        req = '0;
        cyc(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
